fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the processor's program ROM. It owns the program counter (PC) and drives the ROM's enable and address pins. It also absorbs the ROM's one-cycle registered read latency. Each fetched instruction is presented to the decoder over a valid/ready handshake, with support for jumps and a halt at the end of the program.

Parameters:
ADDR_W, 3, width of PC and ROM address
DATA_W, 3, width of instruction word
RESET_ADDR, 0, PC value after reset and after restart
LAST_ADDR, 6, highest valid program address; fetch beyond it halts

Ports:
clock  in  1  processor clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin fetching from RESET_ADDR (accepted in IDLE or HALT)
rom_enable  out  1  ROM read enable, combinational from state
rom_addr  out  ADDR_W  ROM address, equals PC
rom_data  in  DATA_W  ROM registered output, valid the cycle after rom_enable
instr  out  DATA_W  captured instruction, registered
instr_pc  out  ADDR_W  address that instr was fetched from, registered
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  decoder accepts instr this cycle
jump_en  in  1  with an accepted handshake: next PC = jump_addr
jump_addr  in  ADDR_W  jump target
busy  out  1  high in every state except IDLE and HALT
halt  out  1  high in HALT state

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE, PC = RESET_ADDR, instr = 0, instr_pc = 0.
  - instr_valid = 0, halt = 0, busy = 0, rom_enable = 0.
  - Reset mid-fetch discards any in-flight instruction.
- States: IDLE, FETCH, CAPTURE, VALID, HALT.
- IDLE:
  - start=1 → PC <= RESET_ADDR, go to FETCH.
  - Otherwise stay.
- FETCH:
  - rom_enable=1, rom_addr=PC.
  - Unconditionally go to CAPTURE; the ROM registers its output on this edge.
- CAPTURE:
  - rom_enable=0.
  - Latch instr <= rom_data and instr_pc <= PC, then go to VALID.
- VALID:
  - instr_valid=1; instr and instr_pc hold stable while instr_ready=0.
  - On instr_valid & instr_ready, form next = jump_en ? {0,jump_addr} : PC+1, computed ADDR_W+1 bits wide so there is no silent wrap.
  - If next > LAST_ADDR → HALT (PC unchanged). Otherwise PC <= next[ADDR_W-1:0] → FETCH.
- Fetch latency: start to first instr_valid = 3 cycles (IDLE→FETCH→CAPTURE→VALID).
- Throughput: one instruction per 3 cycles when instr_ready is held high.
- HALT:
  - halt=1, instr_valid=0, rom_enable=0.
  - start=1 → PC <= RESET_ADDR → FETCH.
  - Otherwise stay.
- Boundary rules:
  - jump_en is ignored unless a handshake completes the same cycle.
  - start is ignored in FETCH, CAPTURE and VALID.
  - Jump to PC (self-loop) is legal and refetches the same address.
  - PC = LAST_ADDR with no jump → HALT after handshake.
  - PC = 7 with ADDR_W=3 and no jump: next = 8, so HALT.
  - instr_ready high outside VALID has no effect.
- rom_enable is never high in two consecutive cycles.
- rom_addr changes only on edges where rom_enable was low in the prior cycle.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE, FETCH, CAPTURE, VALID, HALT);
  - ADDR_W/DATA_W defaults;
  - RESET_ADDR/LAST_ADDR constants shared with the ROM and the decoder.
- One natural sub-module, pc_reg, owns the PC:
  - asynchronous active-low reset;
  - load of RESET_ADDR;
  - load of jump_addr;
  - increment with overflow flag.
- The FSM and instruction register stay in fetch_ctrl.

Test Plan:
- ROM model with addr0..6 = 101,010,111,110,101,100,011; start pulse, instr_ready tied 1:
  - instr sequence 101,010,111,110,101,100,011 at instr_pc 0..6, each valid 1 cycle, 3 cycles apart;
  - then halt=1, busy=0.
- Backpressure: instr_ready=0 for 5 cycles at instr_pc=2:
  - instr=111 and instr_pc=2 held stable with instr_valid=1;
  - rom_enable stays 0;
  - next fetch at addr 3 only after ready.
- Jump: handshake at instr_pc=1 with jump_en=1, jump_addr=5:
  - next instr=100 at instr_pc=5;
  - after that, 011 at 6, then HALT.
- Out-of-range jump: handshake with jump_en=1, jump_addr=7 → HALT, no ROM access to 7.
- Mid-fetch reset and restart:
  - reset_n low during CAPTURE → all outputs at reset values immediately;
  - after release, start → first instr=101 at instr_pc=0;
  - in HALT, start → refetch from 0.
- Ignored inputs:
  - start during VALID → no effect;
  - jump_en=1 with instr_ready=0 → PC unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: sequencer state encoding and program-space constants.
// Imported by the fetch sequencer, its PC register and its bus interface.
// RESET_ADDR/LAST_ADDR are shared with the ROM and decoder so all agree on program bounds.
package fetch_pkg;

  localparam int ADDR_W_DEF     = 3;
  localparam int DATA_W_DEF     = 3;
  localparam int RESET_ADDR_DEF = 0;
  localparam int LAST_ADDR_DEF  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_VALID,
    ST_HALT
  } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bus bundle: ROM read port plus the instruction valid/ready channel to the decoder.
// master = fetch sequencer side (drives ROM address and instruction).
// slave  = ROM/decoder side (returns ROM data, handshake ready and jump request).
interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              rom_enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output rom_enable, rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  rom_enable, rom_addr, instr, instr_pc, instr_valid,
    output rom_data, instr_ready, jump_en, jump_addr
  );

endinterface

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter: loads RESET_ADDR on restart, else advances to jump target or PC+1.
// Ports: clock/reset_n, load_reset, advance, sel_jump, jump_addr in; pc, next_pc, overflow out.
// next_pc is one bit wider than the PC so a carry past the top address is visible.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_reset,
  input  logic              advance,
  input  logic              sel_jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   next_pc,
  output logic              overflow
);

  always_comb begin
    next_pc = {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};
    if (sel_jump) begin
      next_pc = {1'b0, jump_addr};
    end
  end

  assign overflow = next_pc[ADDR_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= ADDR_W'(RESET_ADDR);
    end else if (load_reset) begin
      pc <= ADDR_W'(RESET_ADDR);
    end else if (advance) begin
      pc <= next_pc[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: walks the ROM from RESET_ADDR, one instruction every 3 cycles.
// Ports: clock, reset_n, start in; bus (ROM port + instr valid/ready + jump) master; busy, halt out.
// Decoder stalls hold instr/instr_pc stable and keep the ROM idle; fetch past LAST_ADDR halts.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RESET_ADDR = RESET_ADDR_DEF,
  parameter int LAST_ADDR  = LAST_ADDR_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  fetch_ctrl_if.master bus,
  output logic         busy,
  output logic         halt
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   next_pc;
  logic              overflow;
  logic              fire;
  logic              load_reset;
  logic              beyond_last;
  logic              advance;

  assign fire       = (state == ST_VALID) && bus.instr_ready;
  assign load_reset = start && ((state == ST_IDLE) || (state == ST_HALT));
  // A carry out of the PC means the target is past the top of the address space.
  assign beyond_last = overflow || (next_pc[ADDR_W-1:0] > ADDR_W'(LAST_ADDR));
  // PC only moves on an in-range handshake; a halting handshake leaves it as is.
  assign advance    = fire && !beyond_last;

  pc_reg #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_reg (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_reset (load_reset),
    .advance    (advance),
    .sel_jump   (bus.jump_en),
    .jump_addr  (bus.jump_addr),
    .pc         (pc),
    .next_pc    (next_pc),
    .overflow   (overflow)
  );

  // FETCH lasts exactly one cycle, so the enable can never be high twice in a row.
  assign bus.rom_enable = (state == ST_FETCH);
  assign bus.rom_addr   = pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
      halt            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
            halt  <= 1'b0;
          end
        end
        ST_FETCH: begin
          // ROM registers its output on this edge; data is readable in CAPTURE.
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          bus.instr       <= bus.rom_data;
          bus.instr_pc    <= pc;
          bus.instr_valid <= 1'b1;
          state           <= ST_VALID;
        end
        ST_VALID: begin
          if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            if (beyond_last) begin
              state <= ST_HALT;
              halt  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: begin
          state           <= ST_IDLE;
          bus.instr_valid <= 1'b0;
          busy            <= 1'b0;
          halt            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: registered ROM model, directed scenarios and a randomized run.
// Expected behaviour comes from a program-level model (next address, halt rule, 3-cycle cadence).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fetch_ctrl;

  logic clock;
  logic reset_n;
  logic start;
  logic busy;
  logic halt;

  int checks = 0;
  int errors = 0;
  int rom7_hits = 0;

  logic [2:0] rom [8];

  fetch_ctrl_if #(.ADDR_W(3), .DATA_W(3)) bus ();

  fetch_ctrl #(
    .ADDR_W     (3),
    .DATA_W     (3),
    .RESET_ADDR (0),
    .LAST_ADDR  (6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halt    (halt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-output program ROM.
  always @(posedge clock) begin
    if (bus.rom_enable === 1'b1) begin
      bus.rom_data <= rom[bus.rom_addr];
      if (bus.rom_addr === 3'd7) rom7_hits <= rom7_hits + 1;
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid_pc(input int pc, input int budget, output bit ok);
    int waited;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < budget) begin
      if (bus.instr_valid === 1'b1 && bus.instr_pc === 3'(pc)) ok = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  task automatic wait_halt(output bit ok);
    int waited;
    bus.instr_ready = 1'b1;
    bus.jump_en = 1'b0;
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 60) begin
      if (halt === 1'b1) ok = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    checks++; if (busy !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL reset_busy_halt got %b%b want 00", busy, halt); end
    checks++; if (bus.rom_enable !== 1'b0 || bus.rom_addr !== 3'd0) begin errors++; $display("FAIL reset_rom got en=%b addr=%0d want 0/0", bus.rom_enable, bus.rom_addr); end
    checks++; if (bus.instr !== 3'd0 || bus.instr_pc !== 3'd0) begin errors++; $display("FAIL reset_instr got %b@%0d want 000@0", bus.instr, bus.instr_pc); end
    reset_n = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || bus.rom_enable !== 1'b0) begin errors++; $display("FAIL idle_hold got busy=%b en=%b want 0/0", busy, bus.rom_enable); end
  endtask

  task automatic test_sequential();
    int k;
    bus.instr_ready = 1'b1;
    bus.jump_en = 1'b0;
    pulse_start();
    k = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (bus.instr_valid === 1'b1) begin
        checks++;
        if (k > 6 || cyc != 3 + 3 * k || bus.instr_pc !== 3'(k) || bus.instr !== rom[k]) begin
          errors++;
          $display("FAIL seq_instr got %b@%0d cycle %0d want %b@%0d cycle %0d", bus.instr, bus.instr_pc, cyc, rom[k], k, 3 + 3 * k);
        end
        k++;
      end
      if (cyc < 22) tick();
    end
    checks++; if (k != 7) begin errors++; $display("FAIL seq_count got %0d want 7", k); end
    checks++; if (halt !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL seq_halt got halt=%b busy=%b want 1/0", halt, busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_valid_pc(2, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_reach got timeout want instr_pc 2"); end
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 3'b111 || bus.instr_pc !== 3'd2 || bus.rom_enable !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v=%b %b@%0d en=%b want 1 111@2 en=0", bus.instr_valid, bus.instr, bus.instr_pc, bus.rom_enable);
      end
    end
    bus.instr_ready = 1'b1;
    tick();
    checks++; if (bus.rom_enable !== 1'b1 || bus.rom_addr !== 3'd3) begin errors++; $display("FAIL bp_refetch got en=%b addr=%0d want 1/3", bus.rom_enable, bus.rom_addr); end
    repeat (2) tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 3'b110 || bus.instr_pc !== 3'd3) begin errors++; $display("FAIL bp_next got v=%b %b@%0d want 1 110@3", bus.instr_valid, bus.instr, bus.instr_pc); end
    wait_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_halt got timeout want halt"); end
  endtask

  task automatic test_jump();
    bit ok;
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_valid_pc(1, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL jmp_reach got timeout want instr_pc 1"); end
    bus.jump_en = 1'b1;
    bus.jump_addr = 3'd5;
    tick();
    bus.jump_en = 1'b0;
    checks++; if (bus.rom_enable !== 1'b1 || bus.rom_addr !== 3'd5) begin errors++; $display("FAIL jmp_fetch got en=%b addr=%0d want 1/5", bus.rom_enable, bus.rom_addr); end
    repeat (2) tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 3'b100 || bus.instr_pc !== 3'd5) begin errors++; $display("FAIL jmp_target got v=%b %b@%0d want 1 100@5", bus.instr_valid, bus.instr, bus.instr_pc); end
    repeat (3) tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 3'b011 || bus.instr_pc !== 3'd6) begin errors++; $display("FAIL jmp_after got v=%b %b@%0d want 1 011@6", bus.instr_valid, bus.instr, bus.instr_pc); end
    tick();
    checks++; if (halt !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL jmp_halt got halt=%b busy=%b want 1/0", halt, busy); end
  endtask

  task automatic test_jump_oob();
    bit ok;
    int hits0;
    hits0 = rom7_hits;
    bus.instr_ready = 1'b1;
    pulse_start();
    wait_valid_pc(0, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL oob_reach got timeout want instr_pc 0"); end
    bus.jump_en = 1'b1;
    bus.jump_addr = 3'd7;
    tick();
    bus.jump_en = 1'b0;
    checks++; if (halt !== 1'b1 || bus.instr_valid !== 1'b0 || bus.rom_enable !== 1'b0) begin errors++; $display("FAIL oob_halt got halt=%b v=%b en=%b want 1/0/0", halt, bus.instr_valid, bus.rom_enable); end
    repeat (4) tick();
    checks++; if (rom7_hits != hits0 || halt !== 1'b1) begin errors++; $display("FAIL oob_noread got reads7=%0d halt=%b want 0/1", rom7_hits - hits0, halt); end
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    bus.instr_ready = 1'b1;
    pulse_start();
    checks++; if (bus.rom_enable !== 1'b1) begin errors++; $display("FAIL mid_fetch got en=%b want 1", bus.rom_enable); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || halt !== 1'b0 || bus.instr_valid !== 1'b0 || bus.rom_enable !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl got busy=%b halt=%b v=%b en=%b want 0000", busy, halt, bus.instr_valid, bus.rom_enable); end
    checks++; if (bus.instr !== 3'd0 || bus.instr_pc !== 3'd0 || bus.rom_addr !== 3'd0) begin errors++; $display("FAIL mid_reset_dat got %b@%0d addr=%0d want 000@0 addr 0", bus.instr, bus.instr_pc, bus.rom_addr); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    repeat (2) tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 3'b101 || bus.instr_pc !== 3'd0) begin errors++; $display("FAIL mid_restart got v=%b %b@%0d want 1 101@0", bus.instr_valid, bus.instr, bus.instr_pc); end
    wait_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_halt got timeout want halt"); end
    pulse_start();
    checks++; if (bus.rom_enable !== 1'b1 || bus.rom_addr !== 3'd0 || halt !== 1'b0) begin errors++; $display("FAIL halt_restart got en=%b addr=%0d halt=%b want 1/0/0", bus.rom_enable, bus.rom_addr, halt); end
    repeat (2) tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== 3'b101 || bus.instr_pc !== 3'd0) begin errors++; $display("FAIL halt_refetch got v=%b %b@%0d want 1 101@0", bus.instr_valid, bus.instr, bus.instr_pc); end
    wait_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL halt_drain got timeout want halt"); end
  endtask

  task automatic test_ignored();
    bit ok;
    bus.instr_ready = 1'b0;
    pulse_start();
    repeat (2) tick();
    start = 1'b1;
    bus.jump_en = 1'b1;
    bus.jump_addr = 3'd4;
    tick();
    start = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 3'd0 || bus.instr !== 3'b101 || bus.rom_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ign_start got v=%b %b@%0d en=%b busy=%b want 1 101@0 0 1", bus.instr_valid, bus.instr, bus.instr_pc, bus.rom_enable, busy); end
    tick();
    checks++; if (bus.rom_addr !== 3'd0 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL ign_jump got pc=%0d v=%b want 0/1", bus.rom_addr, bus.instr_valid); end
    bus.jump_en = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    checks++; if (bus.rom_enable !== 1'b1 || bus.rom_addr !== 3'd1) begin errors++; $display("FAIL ign_next got en=%b addr=%0d want 1/1", bus.rom_enable, bus.rom_addr); end
    wait_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_halt got timeout want halt"); end
  endtask

  // Program-level model: after a start or accepted instruction the next one shows up
  // three cycles later; the next address is the jump target or PC+1, and anything
  // past address 6 ends the program.
  task automatic test_random();
    bit m_halted;
    int m_pc;
    int m_pend;
    int nxt;
    bit exp_valid;
    bit prev_en;
    bit rdy, jmp, st;
    int ja;
    m_halted = 1'b1;
    m_pc = 0;
    m_pend = 0;
    prev_en = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (!m_halted && m_pend > 0) m_pend--;
      exp_valid = !m_halted && (m_pend == 0);
      checks++;
      if (bus.instr_valid !== exp_valid || halt !== m_halted || busy !== !m_halted) begin
        errors++;
        $display("FAIL rnd_ctl cycle %0d got v=%b halt=%b busy=%b want v=%b halt=%b busy=%b", cyc, bus.instr_valid, halt, busy, exp_valid, m_halted, !m_halted);
      end
      if (exp_valid) begin
        checks++;
        if (bus.instr_pc !== 3'(m_pc) || bus.instr !== rom[m_pc]) begin
          errors++;
          $display("FAIL rnd_instr cycle %0d got %b@%0d want %b@%0d", cyc, bus.instr, bus.instr_pc, rom[m_pc], m_pc);
        end
      end
      if (bus.rom_enable === 1'b1) begin
        checks++;
        if (prev_en || bus.rom_addr !== 3'(m_pc)) begin
          errors++;
          $display("FAIL rnd_rom cycle %0d got addr=%0d back2back=%b want addr=%0d back2back=0", cyc, bus.rom_addr, prev_en, m_pc);
        end
      end
      prev_en = (bus.rom_enable === 1'b1);
      rdy = ($urandom_range(0, 3) != 0);
      jmp = ($urandom_range(0, 3) == 0);
      ja  = $urandom_range(0, 7);
      st  = ($urandom_range(0, 9) == 0);
      if (m_halted && st) begin
        m_halted = 1'b0;
        m_pc = 0;
        m_pend = 3;
      end else if (exp_valid && rdy) begin
        nxt = jmp ? ja : m_pc + 1;
        if (nxt > 6) m_halted = 1'b1;
        else begin
          m_pc = nxt;
          m_pend = 3;
        end
      end
      start = st;
      bus.instr_ready = rdy;
      bus.jump_en = jmp;
      bus.jump_addr = 3'(ja);
    end
    start = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
  endtask

  initial begin
    rom[0] = 3'b101; rom[1] = 3'b010; rom[2] = 3'b111; rom[3] = 3'b110;
    rom[4] = 3'b101; rom[5] = 3'b100; rom[6] = 3'b011; rom[7] = 3'b000;
    reset_n = 1'b0;
    start = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_addr = 3'd0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump();
    test_jump_oob();
    test_reset_midfetch();
    test_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
